// File: rtl/uart_pkg.sv
// Shared UART receive-path types and constants.
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int UART_RX_FIFO_DEPTH = 16;

  typedef struct packed {
    logic                   err;
    logic [UART_DATA_W-1:0] data;
  } uart_rx_entry_t;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Handshake and status bundle between uart_rx, the receive FIFO and the register block.
interface uart_rx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic                   wr_valid_i;
  logic [UART_DATA_W-1:0] wr_data_i;
  logic                   wr_err_i;
  logic                   rd_en_i;
  logic [UART_DATA_W-1:0] rd_data_o;
  logic                   rd_err_o;
  logic                   empty_o;
  logic                   full_o;
  logic [LW-1:0]          level_o;
  logic                   flush_i;
  logic                   clr_overrun_i;
  logic                   overrun_o;
  logic [LW-1:0]          thresh_i;
  logic                   thresh_int_o;
  logic                   timeout_int_o;

  modport slave (
    input  wr_valid_i, wr_data_i, wr_err_i, rd_en_i, flush_i, clr_overrun_i, thresh_i,
    output rd_data_o, rd_err_o, empty_o, full_o, level_o, overrun_o, thresh_int_o,
           timeout_int_o
  );

  modport master (
    output wr_valid_i, wr_data_i, wr_err_i, rd_en_i, flush_i, clr_overrun_i, thresh_i,
    input  rd_data_o, rd_err_o, empty_o, full_o, level_o, overrun_o, thresh_int_o,
           timeout_int_o
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// FIFO storage: DEPTH x entry register array, one write port, one asynchronous read port.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic           clk_i,
  input  logic           we,
  input  logic [AW-1:0]  waddr,
  input  uart_rx_entry_t wdata,
  input  logic [AW-1:0]  raddr,
  output uart_rx_entry_t rdata
);

  uart_rx_entry_t mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with level, overrun and threshold interrupt.
// Optional idle-data timeout interrupt enabled by defining UART_RX_FIFO_TIMEOUT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH          = UART_RX_FIFO_DEPTH,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic          clk_i,
  input  logic          rst_i,
  uart_rx_fifo_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]    wr_ptr;
  logic [AW:0]    rd_ptr;
  logic           empty;
  logic           full;
  logic           push;
  logic           pop;
  logic           ovr_set;
  logic           overrun;
  uart_rx_entry_t wr_entry;
  uart_rx_entry_t rd_entry;

  function automatic logic thresh_hit(input logic [AW:0] level, input logic [AW:0] thresh);
    return (thresh != '0) && (level >= thresh);
  endfunction

  // Extra wrap bit distinguishes full from empty when the indices coincide.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

  assign pop     = bus.rd_en_i & ~empty;
  assign push    = bus.wr_valid_i & (~full | pop);
  assign ovr_set = bus.wr_valid_i & full & ~pop & ~bus.flush_i;

  assign wr_entry = '{err: bus.wr_err_i, data: bus.wr_data_i};

  uart_fifo_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk_i (clk_i),
    .we    (push & ~bus.flush_i),
    .waddr (wr_ptr[AW-1:0]),
    .wdata (wr_entry),
    .raddr (rd_ptr[AW-1:0]),
    .rdata (rd_entry)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // A fresh drop outranks a same-cycle clear so no overrun event is ever lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                  overrun <= 1'b0;
    else if (ovr_set)           overrun <= 1'b1;
    else if (bus.clr_overrun_i) overrun <= 1'b0;
  end

  assign bus.rd_data_o    = empty ? '0 : rd_entry.data;
  assign bus.rd_err_o     = empty ? 1'b0 : rd_entry.err;
  assign bus.empty_o      = empty;
  assign bus.full_o       = full;
  assign bus.level_o      = wr_ptr - rd_ptr;
  assign bus.overrun_o    = overrun;
  assign bus.thresh_int_o = thresh_hit(wr_ptr - rd_ptr, bus.thresh_i);

`ifdef UART_RX_FIFO_TIMEOUT_EN
  localparam int            TW        = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] idle_cnt;
  logic [TW-1:0] idle_cnt_nxt;
  logic          tmo_q;

  // Counter saturates at the limit so the interrupt holds until activity or drain.
  always_comb begin
    idle_cnt_nxt = idle_cnt;
    if (push | pop | bus.flush_i | empty) idle_cnt_nxt = '0;
    else if (idle_cnt != TMO_LIMIT)       idle_cnt_nxt = idle_cnt + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idle_cnt <= '0;
      tmo_q    <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
      tmo_q    <= (idle_cnt_nxt == TMO_LIMIT);
    end
  end

  assign bus.timeout_int_o = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg    = (TIMEOUT_CYCLES == 0);
  assign bus.timeout_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Randomised and directed bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int TMO   = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .DEPTH          (DEPTH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] q[$];
  logic       ovr_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int  n;
    logic [7:0] exp_d;
    logic       exp_e;
    n     = q.size();
    exp_d = (n > 0) ? q[0][7:0] : 8'h00;
    exp_e = (n > 0) ? q[0][8]   : 1'b0;
    chk({tag, ":empty"},   32'(bus.empty_o),      32'(n == 0));
    chk({tag, ":full"},    32'(bus.full_o),       32'(n == DEPTH));
    chk({tag, ":level"},   32'(bus.level_o),      32'(n));
    chk({tag, ":data"},    32'(bus.rd_data_o),    32'(exp_d));
    chk({tag, ":err"},     32'(bus.rd_err_o),     32'(exp_e));
    chk({tag, ":overrun"}, 32'(bus.overrun_o),    32'(ovr_m));
    chk({tag, ":thresh"},  32'(bus.thresh_int_o),
        32'((bus.thresh_i != 0) && (n >= int'(bus.thresh_i))));
`ifndef UART_RX_FIFO_TIMEOUT_EN
    chk({tag, ":tmo"},     32'(bus.timeout_int_o), 32'(0));
`endif
  endtask

  // One clock: apply inputs, let the edge happen, advance the model, settle.
  task automatic step(input logic wv, input logic [7:0] wd, input logic we,
                      input logic re, input logic fl, input logic co);
    logic pop_m;
    logic set_m;
    bus.wr_valid_i    = wv;
    bus.wr_data_i     = wd;
    bus.wr_err_i      = we;
    bus.rd_en_i       = re;
    bus.flush_i       = fl;
    bus.clr_overrun_i = co;
    @(posedge clk);
    pop_m = re && (q.size() > 0);
    set_m = 1'b0;
    if (fl) begin
      q.delete();
    end else begin
      if (wv && q.size() == DEPTH && !pop_m) set_m = 1'b1;
      if (pop_m) void'(q.pop_front());
      if (wv && q.size() < DEPTH) q.push_back({we, wd});
    end
    if (set_m)   ovr_m = 1'b1;
    else if (co) ovr_m = 1'b0;
    #1;
    bus.wr_valid_i    = 1'b0;
    bus.rd_en_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.clr_overrun_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] d, input logic e);
    step(1'b1, d, e, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic flush();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  initial begin
    bus.wr_valid_i    = 1'b0;
    bus.wr_data_i     = 8'h00;
    bus.wr_err_i      = 1'b0;
    bus.rd_en_i       = 1'b0;
    bus.flush_i       = 1'b0;
    bus.clr_overrun_i = 1'b0;
    bus.thresh_i      = '0;

    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    chk("reset:tmo", 32'(bus.timeout_int_o), 32'(0));
    @(negedge clk);
    rst = 1'b0;

    // Single byte in and out
    push(8'hA5, 1'b0);
    check_all("t1_push");
    chk("t1_data", 32'(bus.rd_data_o), 32'h0000_00A5);
    pop1();
    check_all("t1_pop");

    // Fill, overrun, ordered drain, clear
    for (int i = 0; i < DEPTH; i++) push(8'(i), 1'b0);
    check_all("t2_full");
    push(8'hFF, 1'b0);
    check_all("t2_drop");
    chk("t2_ovr", 32'(bus.overrun_o), 32'(1));
    for (int i = 0; i < DEPTH; i++) begin
      chk("t2_order", 32'(bus.rd_data_o), 32'(i));
      pop1();
    end
    check_all("t2_drained");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    check_all("t2_clr");

    // Push and pop together while full
    for (int i = 0; i < DEPTH; i++) push(8'(8'h10 + i), 1'(i & 1));
    step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    check_all("t3_pushpop_full");
    chk("t3_level", 32'(bus.level_o), 32'(DEPTH));
    for (int i = 0; i < DEPTH; i++) begin
      if (i == DEPTH - 1) begin
        chk("t3_last", 32'(bus.rd_data_o), 32'h0000_0055);
        chk("t3_last_err", 32'(bus.rd_err_o), 32'(1));
      end
      pop1();
    end
    check_all("t3_drained");

    // Threshold interrupt
    bus.thresh_i = LW'(4);
    for (int i = 0; i < 3; i++) push(8'(8'h20 + i), 1'b0);
    check_all("t4_below");
    push(8'h23, 1'b0);
    check_all("t4_at");
    chk("t4_int", 32'(bus.thresh_int_o), 32'(1));
    pop1();
    check_all("t4_after_pop");
    while (q.size() < DEPTH) push(8'($urandom), 1'($urandom));
    bus.thresh_i = '0;
    #1;
    check_all("t4_disabled");
    flush();
    check_all("t4_flush");

    // Flush races a push; then a long run across pointer wrap
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i), 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b0);
    check_all("t5_flush");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'($urandom), 1'($urandom), 1'(q.size() >= 3), 1'b0, 1'b0);
      check_all("t5_wrap");
    end

    // Fully random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 31) == 0) bus.thresh_i = LW'($urandom_range(0, DEPTH));
      step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom),
           1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 49) == 0),
           1'($urandom_range(0, 19) == 0));
      check_all("rand");
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    flush();
    push(8'h42, 1'b0);
    repeat (TMO - 1) idle();
    chk("t6_tmo_early", 32'(bus.timeout_int_o), 32'(0));
    idle();
    chk("t6_tmo_fire", 32'(bus.timeout_int_o), 32'(1));
    idle();
    chk("t6_tmo_hold", 32'(bus.timeout_int_o), 32'(1));
    pop1();
    chk("t6_tmo_pop", 32'(bus.timeout_int_o), 32'(0));
`endif

    // Asynchronous reset in the middle of activity
    flush();
    for (int i = 0; i < 3; i++) push(8'(8'h60 + i), 1'b1);
    repeat (3) idle();
    rst = 1'b1;
    #1;
    q.delete();
    ovr_m = 1'b0;
    check_all("t6_async_rst");
    chk("t6_rst_tmo", 32'(bus.timeout_int_o), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    push(8'h99, 1'b1);
    check_all("t6_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
